// File: rtl/enigma_pkg.sv
// Shared types, constants and the PS/2 set-2 letter map used by the
// Enigma keyboard input path and everything that consumes its letter codes.
package enigma_pkg;

    // 1-based letter code used across the design: A=1 ... Z=26, 0 = no key.
    typedef logic [4:0] letter_t;
    localparam letter_t LETTER_NONE = 5'd0;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic letter_t scancode_to_letter(input logic [7:0] code);
        letter_t letter;
        case (code)
            8'h1C: letter = 5'd1;
            8'h32: letter = 5'd2;
            8'h21: letter = 5'd3;
            8'h23: letter = 5'd4;
            8'h24: letter = 5'd5;
            8'h2B: letter = 5'd6;
            8'h34: letter = 5'd7;
            8'h33: letter = 5'd8;
            8'h43: letter = 5'd9;
            8'h3B: letter = 5'd10;
            8'h42: letter = 5'd11;
            8'h4B: letter = 5'd12;
            8'h3A: letter = 5'd13;
            8'h31: letter = 5'd14;
            8'h44: letter = 5'd15;
            8'h4D: letter = 5'd16;
            8'h15: letter = 5'd17;
            8'h2D: letter = 5'd18;
            8'h1B: letter = 5'd19;
            8'h2C: letter = 5'd20;
            8'h3C: letter = 5'd21;
            8'h2A: letter = 5'd22;
            8'h1D: letter = 5'd23;
            8'h22: letter = 5'd24;
            8'h35: letter = 5'd25;
            8'h1A: letter = 5'd26;
            default: letter = LETTER_NONE;
        endcase
        return letter;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises the raw pins, deserialises
// 11-bit frames on falling PS/2 clock edges and abandons stalled frames.
module ps2_rx_frame
    import enigma_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    rx_state_e       state;
    rx_state_e       state_next;
    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_ok;
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;

    logic start_en;
    logic shift_en;
    logic parity_en;
    logic good_d;
    logic err_d;

    // Lines idle high, so the synchroniser resets high to avoid a false edge.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking = here would make results depend on statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_in = data_sync[SYNC_STAGES-1];

    // An edge always restarts the idle timer, so it wins over a timeout.
    assign timed_out = (state != RX_IDLE) && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= RX_IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_next = state;
        if (timed_out) begin
            state_next = RX_IDLE;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!bit_in) state_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 4'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                RX_STOP:   state_next = RX_IDLE;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        start_en  = 1'b0;
        shift_en  = 1'b0;
        parity_en = 1'b0;
        good_d    = 1'b0;
        err_d     = timed_out;
        if (fall) begin
            case (state)
                RX_IDLE:   start_en  = !bit_in;
                RX_DATA:   shift_en  = 1'b1;
                RX_PARITY: parity_en = 1'b1;
                RX_STOP: begin
                    good_d = bit_in && parity_ok;
                    err_d  = !(bit_in && parity_ok);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            parity_ok  <= 1'b0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            byte_valid <= good_d;
            frame_err  <= err_d;

            if (start_en) bit_cnt <= 4'd0;
            if (shift_en) begin
                shreg   <= {bit_in, shreg[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (parity_en) parity_ok <= ^{shreg, bit_in};
            if (good_d)    rx_byte   <= shreg;

            if (fall || state == RX_IDLE) to_cnt <= '0;
            else if (to_cnt != TO_MAX)    to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/enigma_ps2_keyboard.sv
// Enigma keyboard input: turns PS/2 set-2 scancodes into the held letter
// code (1..26, 0 = none) plus press/release/error pulses for the datapath.
module enigma_ps2_keyboard
    import enigma_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [4:0] letter_out,
    output logic       press_pulse_out,
    output logic       release_pulse_out,
    output logic       frame_err_out,
    output logic [7:0] scancode_out
);

    logic [7:0] rx_byte;
    logic       byte_valid;

    letter_t letter_q;
    letter_t letter_next;
    letter_t code_letter;
    logic    break_pend;
    logic    break_next;
    logic    ext_pend;
    logic    ext_next;
    logic    press_q;
    logic    press_next;
    logic    release_q;
    logic    release_next;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .frame_err   (frame_err_out)
    );

    assign code_letter = scancode_to_letter(rx_byte);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            letter_q   <= LETTER_NONE;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            letter_q   <= letter_next;
            break_pend <= break_next;
            ext_pend   <= ext_next;
            press_q    <= press_next;
            release_q  <= release_next;
        end
    end

    // Any byte other than a prefix consumes both prefix flags. A key switch
    // reports only the new press; a break for a key not held is dropped.
    always_comb begin
        letter_next  = letter_q;
        break_next   = break_pend;
        ext_next     = ext_pend;
        press_next   = 1'b0;
        release_next = 1'b0;
        if (byte_valid) begin
            if (rx_byte == SC_BREAK) begin
                break_next = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_next = 1'b1;
            end else begin
                break_next = 1'b0;
                ext_next   = 1'b0;
                if (!ext_pend && code_letter != LETTER_NONE) begin
                    if (break_pend) begin
                        if (code_letter == letter_q) begin
                            letter_next  = LETTER_NONE;
                            release_next = 1'b1;
                        end
                    end else if (code_letter != letter_q) begin
                        letter_next = code_letter;
                        press_next  = 1'b1;
                    end
                end
            end
        end
    end

    assign letter_out        = letter_q;
    assign press_pulse_out   = press_q;
    assign release_pulse_out = release_q;
    assign scancode_out      = rx_byte;

endmodule

// File: tb/tb_enigma_ps2_keyboard.sv
// Scoreboard bench for enigma_ps2_keyboard: directed PS/2 frames push expected
// pulses into a queue that an independent monitor drains and compares.
module tb_enigma_ps2_keyboard;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [4:0] letter_out;
    logic       press_pulse_out;
    logic       release_pulse_out;
    logic       frame_err_out;
    logic [7:0] scancode_out;

    enigma_ps2_keyboard #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_data_in       (ps2_data_in),
        .letter_out        (letter_out),
        .press_pulse_out   (press_pulse_out),
        .release_pulse_out (release_pulse_out),
        .frame_err_out     (frame_err_out),
        .scancode_out      (scancode_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef enum {EV_PRESS, EV_RELEASE, EV_ERR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [4:0] letter;
        int         min_lat;
        int         max_lat;
        string      name;
    } ev_t;

    ev_t sb_q[$];
    int  last_fall_cyc = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic expect_ev(input ev_kind_e kind, input logic [4:0] letter,
                             input int lo, input int hi, input string name);
        ev_t e;
        e.kind = kind; e.letter = letter; e.min_lat = lo; e.max_lat = hi; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic consume(input ev_kind_e kind);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d letter %0d, expected none (cycle %0d)",
                     kind, letter_out, cyc);
        end else begin
            e = sb_q.pop_front();
            check({e.name, "_kind"}, kind, e.kind);
            check({e.name, "_letter"}, letter_out, e.letter);
            check_range({e.name, "_latency"}, cyc - last_fall_cyc, e.min_lat, e.max_lat);
        end
    endtask

    // Monitor: every pulse seen must match the head of the scoreboard.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (press_pulse_out && release_pulse_out)
                check("press_release_exclusive", 1, 0);
            if (press_pulse_out)   consume(EV_PRESS);
            if (release_pulse_out) consume(EV_RELEASE);
            if (frame_err_out)     consume(EV_ERR);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip_par,
                                               input bit bad_stop);
        logic par;
        par = ~^b ^ flip_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        idle(1);
        for (int i = 0; i < nbits; i++) begin
            ps2_data_in = f[i];
            idle(HALF);
            ps2_clk_in    = 1'b0;
            last_fall_cyc = cyc;
            idle(HALF);
            ps2_clk_in = 1'b1;
        end
        ps2_data_in = 1'b1;
        idle(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(make_frame(b, 1'b0, 1'b0), 11);
    endtask

    logic [10:0] partial;

    initial begin
        rst_in      = 1'b1;
        ps2_clk_in  = 1'b1;
        ps2_data_in = 1'b1;
        idle(5);
        check("reset_letter", letter_out, 5'd0);
        check("reset_scancode", scancode_out, 8'h00);
        check("reset_pulses", {press_pulse_out, release_pulse_out, frame_err_out}, 3'b000);
        rst_in = 1'b0;
        idle(10);

        // A make, typematic repeat, then break of the held key
        expect_ev(EV_PRESS, 5'd1, 4, 4, "press_a");
        send_byte(8'h1C);
        check("scancode_1c", scancode_out, 8'h1C);
        check("letter_a", letter_out, 5'd1);
        send_byte(8'h1C);
        check("letter_a_repeat", letter_out, 5'd1);
        send_byte(8'hF0);
        check("scancode_f0", scancode_out, 8'hF0);
        check("letter_a_break_pend", letter_out, 5'd1);
        expect_ev(EV_RELEASE, 5'd0, 4, 4, "release_a");
        send_byte(8'h1C);
        check("letter_a_released", letter_out, 5'd0);

        // Q then Z; breaking Q while Z is held changes nothing
        expect_ev(EV_PRESS, 5'd17, 4, 4, "press_q");
        send_byte(8'h15);
        check("letter_q", letter_out, 5'd17);
        expect_ev(EV_PRESS, 5'd26, 4, 4, "press_z");
        send_byte(8'h1A);
        check("letter_z", letter_out, 5'd26);
        send_byte(8'hF0);
        send_byte(8'h15);
        check("letter_z_after_break_q", letter_out, 5'd26);
        expect_ev(EV_RELEASE, 5'd0, 4, 4, "release_z");
        send_byte(8'hF0);
        send_byte(8'h1A);
        check("letter_z_released", letter_out, 5'd0);

        // Extended prefix swallows the next byte; space is not a letter
        send_byte(8'hE0);
        send_byte(8'h1C);
        check("letter_ext_ignored", letter_out, 5'd0);
        send_byte(8'h29);
        check("scancode_29", scancode_out, 8'h29);
        check("letter_space", letter_out, 5'd0);
        expect_ev(EV_PRESS, 5'd1, 4, 4, "press_a_after_ext");
        send_byte(8'h1C);
        check("letter_a_after_ext", letter_out, 5'd1);
        expect_ev(EV_RELEASE, 5'd0, 4, 4, "release_a2");
        send_byte(8'hF0);
        send_byte(8'h1C);

        // Framing errors: bad parity, then bad stop bit
        expect_ev(EV_ERR, 5'd0, 3, 3, "err_parity");
        send_bits(make_frame(8'h1C, 1'b1, 1'b0), 11);
        check("letter_after_parity_err", letter_out, 5'd0);
        check("scancode_after_parity_err", scancode_out, 8'h1C);
        expect_ev(EV_ERR, 5'd0, 3, 3, "err_stop");
        send_bits(make_frame(8'h1A, 1'b0, 1'b1), 11);
        check("letter_after_stop_err", letter_out, 5'd0);
        check("scancode_after_stop_err", scancode_out, 8'h1C);

        // Stall after four data bits, then recover with a clean frame
        expect_ev(EV_ERR, 5'd0, TIMEOUT, TIMEOUT + 6, "err_timeout");
        send_bits(make_frame(8'h1A, 1'b0, 1'b0), 5);
        idle(TIMEOUT + 60);
        check("letter_after_timeout", letter_out, 5'd0);
        expect_ev(EV_PRESS, 5'd26, 4, 4, "press_z_after_timeout");
        send_byte(8'h1A);
        check("letter_z_after_timeout", letter_out, 5'd26);

        // Reset mid-frame; the trailing parity/stop bits are both 1 and ignored
        partial = make_frame(8'h1B, 1'b0, 1'b0);
        send_bits(partial, 9);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        check("letter_after_midframe_reset", letter_out, 5'd0);
        check("scancode_after_midframe_reset", scancode_out, 8'h00);
        send_bits(partial >> 9, 2);
        idle(TIMEOUT + 60);
        check("letter_after_trailing_bits", letter_out, 5'd0);
        check("scancode_after_trailing_bits", scancode_out, 8'h00);
        expect_ev(EV_PRESS, 5'd1, 4, 4, "press_a_after_reset");
        send_byte(8'h1C);
        check("letter_a_after_reset", letter_out, 5'd1);

        idle(20);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
